redmule_evt_irq_unit: RTL
=========================

// Module: redmule_evt_irq_unit
// PURPOSE
//  Event-to-interrupt stage between the RedMulE accelerator event outputs and the control core's irq_i.
//  - Turns per-core RedMulE event pulses into sticky, maskable, acknowledgeable interrupt lines.
//  - Provides a small register port for mask, pending and overflow status.
//  - Drives wake_o so the complex's clock-gating logic can wake a sleeping core.
// PARAMETERS
//  NumEvt    2   event lines (flattened evt[N_CORES][1:0]); NumEvt + IrqOffset <= NumIrqs
//  IrqOffset 3   irq_o bit index of event 0
//  NumIrqs   32  width of irq_o
//  CntWidth  8   width of each per-event counter (EVT_CNT_EN only); NumEvt*CntWidth <= 32
// PORTS
//  clk_i        in   1                  clock
//  rst_ni       in   1                  reset, asynchronous, active-low
//  clear_i      in   1                  synchronous soft clear (same effect as reset)
//  evt_i        in   NumEvt             RedMulE event lines (pulse or level)
//  irq_o        out  NumIrqs            interrupt lines to core
//  irq_ack_i    in   1                  core interrupt acknowledge (1-cycle pulse)
//  irq_id_i     in   $clog2(NumIrqs)    id of acknowledged interrupt
//  wake_o       out  1                  |(pending & mask)
//  reg_req_i    in   1                  register access request
//  reg_we_i     in   1                  1 = write, 0 = read
//  reg_addr_i   in   4                  byte address; word index = reg_addr_i[3:2]
//  reg_wdata_i  in   32                 write data
//  reg_gnt_o    out  1                  grant
//  reg_rvalid_o out  1                  response valid
//  reg_rdata_o  out  32                 read data
// BEHAVIOUR
//  Reset / clear_i state:
//    mask = '1; pending, ovf, evt_q, counters = '0; reg_rvalid_o = 0; reg_rdata_o = '0.
//  Edge detect:
//    evt_q <= evt_i every cycle; rise[i] = evt_i[i] & ~evt_q[i].
//    A level held N cycles gives exactly one rise.
//  Pending[i]:
//    - Set on rise[i].
//    - Cleared next cycle by irq_ack_i with irq_id_i == IrqOffset+i, or by a write of 1 to PENDING bit i.
//    - Set and clear in the same cycle: set wins, pending stays 1.
//  Overflow ovf[i]:
//    - Sticky; set on rise[i] while pending[i] == 1 and no clear in that cycle.
//    - Cleared only by W1C, reset or clear_i.
//  Outputs:
//    - irq_o[IrqOffset+i] = pending[i] & mask[i]; all other irq_o bits are 0.
//    - irq_o and wake_o are combinational from registers: a rise at edge k drives irq_o after edge k, so latency is 1 cycle.
//    - Masked events still set pending; unmasking later raises irq_o immediately.
//    - Ack with an id outside [IrqOffset, IrqOffset+NumEvt-1] is ignored.
//  Register handshake:
//    - reg_gnt_o = reg_req_i (combinational, never stalls).
//    - reg_rvalid_o is asserted exactly the cycle after each granted access.
//    - reg_rdata_o is registered; it is '0 for writes and held until the next access.
//  Register map (word index):
//    0 MASK     rw   bits[NumEvt-1:0]
//    1 PENDING  r/W1C
//    2 OVF      r/W1C
//    3 COUNT    see CONFIGURATION
//    Unused bits read 0; writes to them are ignored.
//  A read of PENDING in a cycle where it changes returns the pre-update value.
//  Reset asserted mid-transfer drops any outstanding rvalid.
// CONFIGURATION
//  Macro REDMULE_EVT_CNT_EN:
//    Defined:
//      - Per-event saturating CntWidth counter, +1 on each rise[i], sticks at all-ones.
//      - Word 3 reads {.., cnt[1], cnt[0]}, with cnt[i] at bits [i*CntWidth +: CntWidth].
//      - Any write to word 3 zeroes all counters; a rise in that same cycle is lost.
//    Undefined:
//      - No counters are instantiated; word 3 reads 0 and writes are ignored.
// TESTING
//  1 Reset: rst_ni=0 -> irq_o=0, wake_o=0, reg_rvalid_o=0; read word 0 -> 0x3 (NumEvt=2).
//  2 Level hold: evt_i[0]=1 for 5 cycles -> irq_o[3]=1 from the cycle after the rise;
//    ack with id=3 -> irq_o[3]=0 next cycle; ovf=0.
//  3 Overflow and set-wins:
//    (a) two rises on evt 1 without ack -> OVF reads 0x2.
//    (b) rise on evt 1 coincident with ack id=4 -> pending[1] stays 1; OVF W1C 0x2 -> OVF reads 0.
//  4 Mask: write MASK=0x0, pulse evt_i[0] -> irq_o=0, wake_o=0, PENDING reads 0x1;
//    write MASK=0x1 -> irq_o[3]=1 next cycle.
//  5 Ack misuse: ack with id=7 while pending=0x3 -> pending unchanged; W1C PENDING 0x1 -> reads 0x2.
//  6 EVT_CNT_EN:
//    - 300 rises on evt 0 -> word 3 [7:0]=0xFF; write word 3 -> reads 0.
//    - Without the macro, word 3 always reads 0.

Source files
------------

// File: rtl/redmule_evt_irq_unit.sv
// RedMulE event-to-interrupt stage: sticky, maskable, ackable irq lines.
// Optional per-event saturating counters enabled by `define REDMULE_EVT_CNT_EN.
module redmule_evt_irq_unit #(
  parameter int unsigned NumEvt    = 2,
  parameter int unsigned IrqOffset = 3,
  parameter int unsigned NumIrqs   = 32,
  parameter int unsigned CntWidth  = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic [NumEvt-1:0]          evt_i,
  output logic [NumIrqs-1:0]         irq_o,
  input  logic                       irq_ack_i,
  input  logic [$clog2(NumIrqs)-1:0] irq_id_i,
  output logic                       wake_o,
  input  logic                       reg_req_i,
  input  logic                       reg_we_i,
  input  logic [3:0]                 reg_addr_i,
  input  logic [31:0]                reg_wdata_i,
  output logic                       reg_gnt_o,
  output logic                       reg_rvalid_o,
  output logic [31:0]                reg_rdata_o
);

  localparam int unsigned IdW = $clog2(NumIrqs);

  logic [NumEvt-1:0] evt_q;
  logic [NumEvt-1:0] rise;
  logic [NumEvt-1:0] mask_q;
  logic [NumEvt-1:0] mask_d;
  logic [NumEvt-1:0] pend_q;
  logic [NumEvt-1:0] pend_d;
  logic [NumEvt-1:0] ovf_q;
  logic [NumEvt-1:0] ovf_d;
  logic [NumEvt-1:0] ack_clr;
  logic [NumEvt-1:0] pend_clr;
  logic [NumEvt-1:0] ovf_clr;
  logic [NumEvt-1:0] wdata_evt;
  logic [NumEvt-1:0] active;

  logic [1:0]  word;
  logic        wr_acc;
  logic        sel_mask;
  logic        sel_pend;
  logic        sel_ovf;
  logic        sel_cnt;
  logic [31:0] rd_val;
  logic [31:0] cnt_rd;

  assign word      = reg_addr_i[3:2];
  assign wr_acc    = reg_req_i & reg_we_i;
  assign sel_mask  = (word == 2'd0);
  assign sel_pend  = (word == 2'd1);
  assign sel_ovf   = (word == 2'd2);
  assign sel_cnt   = (word == 2'd3);
  assign wdata_evt = reg_wdata_i[NumEvt-1:0];

  assign rise = evt_i & ~evt_q;

  always_comb begin
    ack_clr = '0;
    for (int unsigned i = 0; i < NumEvt; i++) begin
      ack_clr[i] = irq_ack_i &&
                   (irq_id_i == IdW'(IrqOffset + i));
    end
  end

  assign pend_clr = ack_clr
                  | ({NumEvt{wr_acc & sel_pend}} & wdata_evt);
  assign ovf_clr  = {NumEvt{wr_acc & sel_ovf}} & wdata_evt;

  // A rise always wins over a clear in the same cycle.
  assign pend_d = rise | (pend_q & ~pend_clr);
  assign ovf_d  = (rise & pend_q & ~pend_clr)
                | (ovf_q & ~ovf_clr);
  assign mask_d = (wr_acc & sel_mask) ? wdata_evt : mask_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evt_q  <= '0;
      mask_q <= '1;
      pend_q <= '0;
      ovf_q  <= '0;
    end else if (clear_i) begin
      evt_q  <= '0;
      mask_q <= '1;
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      evt_q  <= evt_i;
      mask_q <= mask_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef REDMULE_EVT_CNT_EN
  logic [NumEvt-1:0][CntWidth-1:0] cnt_q;
  logic                            cnt_wr;

  assign cnt_wr = wr_acc & sel_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i || cnt_wr) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NumEvt; i++) begin
        if (rise[i] && !(&cnt_q[i])) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign cnt_rd = 32'(cnt_q);
`else
  assign cnt_rd = '0;
`endif

  assign active = pend_q & mask_q;
  assign wake_o = |active;

  always_comb begin
    irq_o = '0;
    irq_o[IrqOffset +: NumEvt] = active;
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_mask: rd_val[NumEvt-1:0] = mask_q;
      sel_pend: rd_val[NumEvt-1:0] = pend_q;
      sel_ovf:  rd_val[NumEvt-1:0] = ovf_q;
      sel_cnt:  rd_val             = cnt_rd;
      default:  rd_val             = '0;
    endcase
  end

  assign reg_gnt_o = reg_req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_rvalid_o <= 1'b0;
      reg_rdata_o  <= '0;
    end else if (clear_i) begin
      reg_rvalid_o <= 1'b0;
      reg_rdata_o  <= '0;
    end else begin
      reg_rvalid_o <= reg_req_i;
      if (reg_req_i) begin
        reg_rdata_o <= reg_we_i ? '0 : rd_val;
      end
    end
  end

  logic unused;
  assign unused = ^reg_wdata_i ^ ^reg_addr_i[1:0];

endmodule
